// File: rtl/fifo_drain_if.sv
// Output stream of fifo_drain: valid/ready words with start/end-of-burst markers.
// m_parity exists only when FIFO_DRAIN_PARITY_EN is defined.
interface fifo_drain_if;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_sop;
    logic        m_eop;
`ifdef FIFO_DRAIN_PARITY_EN
    logic        m_parity;

    modport master (output m_data, m_valid, m_sop, m_eop, m_parity, input m_ready);
    modport slave  (input m_data, m_valid, m_sop, m_eop, m_parity, output m_ready);
`else
    modport master (output m_data, m_valid, m_sop, m_eop, input m_ready);
    modport slave  (input m_data, m_valid, m_sop, m_eop, output m_ready);
`endif
endinterface

// File: rtl/fifo_drain.sv
// Burst drainer for a 16x32 synchronous FIFO with one-cycle read latency.
// Optional FIFO_DRAIN_PARITY_EN adds a stored even-parity bit per word.
module fifo_drain #(
    parameter int BURST_LEN = 8,
    parameter int TIMEOUT   = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [4:0]   fifo_cnt,
    input  logic         fifo_empty,
    input  logic [31:0]  fifo_dout,
    output logic         fifo_ren,
    output logic         busy,
    fifo_drain_if.master strm
);
    localparam logic [4:0] BLEN = 5'(BURST_LEN);
    localparam logic [7:0] TMO  = 8'(TIMEOUT);
`ifdef FIFO_DRAIN_PARITY_EN
    localparam int EW = 33;
`else
    localparam int EW = 32;
`endif

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t         state, state_nxt;
    logic [7:0]     idle_tmr;
    logic [4:0]     burst_len;
    logic [4:0]     issued;
    logic [4:0]     sent;
    logic           inflight;
    logic [EW-1:0]  buf_mem [4];
    logic [1:0]     wptr, rptr;
    logic [2:0]     buf_cnt;
    logic [EW-1:0]  head;
    logic [EW-1:0]  cap_word;
    logic           m_valid;
    logic           pop;
    logic           last_pop;
    logic           start;

    assign start = (state == IDLE) &&
                   ((fifo_cnt >= BLEN) ||
                    ((TMO != 8'd0) && (idle_tmr >= TMO) && (fifo_cnt != 5'd0)));

    assign m_valid  = (buf_cnt != 3'd0);
    assign pop      = m_valid && strm.m_ready;
    assign last_pop = pop && strm.m_eop;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = READ;
            READ:    if (fifo_ren && (issued + 5'd1 == burst_len)) state_nxt = DRAIN;
            DRAIN:   if (last_pop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: a read only goes out while buffer plus in-flight leaves room for it
    always_comb begin
        busy     = (state != IDLE);
        fifo_ren = 1'b0;
        if ((state == READ) && (issued < burst_len) && !fifo_empty &&
            ((buf_cnt + {2'b00, inflight}) <= 3'd2))
            fifo_ren = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_tmr  <= 8'd0;
            burst_len <= 5'd0;
            issued    <= 5'd0;
            sent      <= 5'd0;
        end else begin
            if (state != IDLE || start || fifo_cnt == 5'd0)
                idle_tmr <= 8'd0;
            else if (idle_tmr != 8'hFF)
                idle_tmr <= idle_tmr + 8'd1;

            if (start) begin
                burst_len <= (fifo_cnt < BLEN) ? fifo_cnt : BLEN;
                issued    <= 5'd0;
                sent      <= 5'd0;
            end else begin
                if (fifo_ren) issued <= issued + 5'd1;
                if (pop)      sent   <= sent + 5'd1;
            end
        end
    end

    // Read-latency tracking and output buffer bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight <= 1'b0;
            wptr     <= 2'd0;
            rptr     <= 2'd0;
            buf_cnt  <= 3'd0;
        end else begin
            inflight <= fifo_ren;
            if (inflight) wptr <= wptr + 2'd1;
            if (pop)      rptr <= rptr + 2'd1;
            buf_cnt <= buf_cnt + {2'b00, inflight} - {2'b00, pop};
        end
    end

`ifdef FIFO_DRAIN_PARITY_EN
    assign cap_word = {^fifo_dout, fifo_dout};
`else
    assign cap_word = fifo_dout;
`endif

    // Storage needs no reset: the pointers and count define what is live
    always_ff @(posedge clk) begin
        if (inflight) buf_mem[wptr] <= cap_word;
    end

    assign head = buf_mem[rptr];

    assign strm.m_valid = m_valid;
    assign strm.m_data  = m_valid ? head[31:0] : 32'd0;
    assign strm.m_sop   = m_valid && (sent == 5'd0);
    assign strm.m_eop   = m_valid && (sent == burst_len - 5'd1);
`ifdef FIFO_DRAIN_PARITY_EN
    assign strm.m_parity = m_valid && head[32];
`endif

endmodule
